fetch_align: RTL and testbench
==============================

FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 clk  input  1  sole clock; all state changes on posedge clk.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 redirect  input  1  the next instruction comes from redirect_pc (branch or flush).
REQ-004 redirect_pc  input  16  byte address of the new stream; odd values legal.
REQ-005 mem_raddr  output  15  word address sent to the instruction port of the word-organised memory.
REQ-006 mem_rdata  input  16  memory word; valid exactly 1 cycle after mem_raddr is presented.
REQ-007 out_valid  output  1  out_ins/out_pc hold a complete instruction.
REQ-008 out_ready  input  1  the downstream decoder accepts the instruction this cycle.
REQ-009 out_ins  output  16  instruction; low byte is at out_pc, high byte is at out_pc+1 (little-endian).
REQ-010 out_pc  output  16  byte address of out_ins.

Function
REQ-011 The block shall hold a byte buffer of 4 bytes (2 words) with a byte count of 0..4, plus a 1-bit in-flight flag for the read issued last cycle.
REQ-012 A transfer shall occur when out_valid=1, out_ready=1 and redirect=0; it removes 2 bytes and advances out_pc by 2, modulo 2^16.
REQ-013 out_valid shall be 1 when the count is at least 2 and redirect=0.
REQ-014 out_ins shall be {byte1, byte0} of the buffer head, whatever the parity of out_pc.
REQ-015 A read shall be issued when: count after this cycle's transfer + 2 x in-flight + 2 <= 4. The issue cycle loads the in-flight flag, and fetch_addr increments modulo 2^15.
REQ-016 Returned words shall append both bytes to the tail, low byte first.
REQ-017 With out_ready held at 1 and no redirect, the block shall sustain 1 instruction per cycle after fill.
REQ-018 redirect shall have priority over every other event in the same cycle. In that cycle:
  - the buffer is cleared and out_valid is forced to 0;
  - a word returning in that cycle is discarded, and a presented instruction is not transferred;
  - mem_raddr = redirect_pc[15:1] combinationally, and fetch_addr becomes redirect_pc[15:1]+1;
  - out_pc becomes redirect_pc;
  - if redirect_pc[0]=1, a skip flag is set.
REQ-019 When the skip flag is set, the next returned word shall append only its high byte, and the flag shall clear.
REQ-020 Latency from redirect in cycle N:
  - even target: out_valid=1 in cycle N+2;
  - odd target: out_valid=1 in cycle N+3.
REQ-021 A redirect on consecutive cycles shall restart the sequence each time; only the last target is delivered.
REQ-022 Buffer full (count 4): no read shall be issued; out_ins is stable while out_ready=0.
REQ-023 Buffer empty: out_valid=0; mem_raddr keeps issuing per REQ-015.
REQ-024 Wrap-around: after word 0x7FFF, fetch_addr shall wrap to 0x0000. An odd out_pc of 0xFFFF shall combine the high byte of word 0x7FFF with the low byte of word 0x0000.
REQ-025 A read shall not be issued when the issue formula of REQ-015 cannot be met; mem_raddr then holds fetch_addr with no effect.

Reset
REQ-026 While rst=1:
  - count=0, in-flight=0, skip=0;
  - fetch_addr=0, out_pc=0x0000;
  - out_valid=0, out_ins=0x0000.
REQ-027 In the first cycle after rst falls (cycle N), mem_raddr shall be 0x0000, and out_valid shall first rise in cycle N+2.
REQ-028 rst asserted mid-stream shall discard the buffered bytes, the in-flight word and the skip flag in the same edge; rst has priority over redirect.

Structure
REQ-029 A shared package shall hold the buffer depth constant (4 bytes) and the word-width constant (16 bits).
REQ-030 The byte buffer with count and append/pop logic shall be one sub-module, fetch_byte_buf; fetch_align holds the issue control, skip flag and pc.

Verification
REQ-031 Reset release, memory[0..3] = 0x1111, 0x2222, 0x3333, 0x4444, out_ready=1 -> out_valid at N+2, then out_ins 0x1111, 0x2222, 0x3333 on consecutive cycles with out_pc 0, 2, 4.
REQ-032 redirect_pc=0x0005 with word2=0xAB12, word3=0xCD34 -> out_valid at N+3, out_ins=0x34AB, out_pc=0x0005, then 0x0007.
REQ-033 out_ready=0 for 5 cycles after fill -> count 4, no read issued, out_ins constant; on release the instructions arrive in order with none lost.
REQ-034 redirect to 0x0010 while out_valid=1 and out_ready=1 -> the old instruction is not transferred, the next delivered out_pc is 0x0010, and the stale returning word is dropped.
REQ-035 redirect_pc=0xFFFF, word 0x7FFF=0x00EE, word 0x0000=0x0077 -> out_ins=0x7700, out_pc=0xFFFF, next out_pc=0x0001.
REQ-036 rst pulse mid-stream with 3 bytes buffered -> out_valid=0 next cycle, and the stream restarts at address 0x0000 per REQ-027.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// Shared constants and bundle types for the fetch aligner.
// Buffer geometry and the word-return push bundle live here.
package fetch_align_pkg;

    localparam int BUF_BYTES = 4;
    localparam int WORD_W = 16;
    localparam int CNT_W = 3;
    localparam int WADDR_W = 15;

    typedef struct packed {
        logic              valid;
        logic              hi_only;
        logic [WORD_W-1:0] word;
    } push_t;

    function automatic logic [CNT_W-1:0] cnt_after(
        input logic [CNT_W-1:0] c,
        input logic             pop
    );
        return pop ? c - CNT_W'(2) : c;
    endfunction

endpackage

// File: rtl/fetch_align_if.sv
// Memory read port, redirect and instruction output bundle.
// master = environment side, slave = fetch_align.
interface fetch_align_if;
    import fetch_align_pkg::*;

    logic               redirect;
    logic [WORD_W-1:0]  redirect_pc;
    logic [WADDR_W-1:0] mem_raddr;
    logic [WORD_W-1:0]  mem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_ins;
    logic [WORD_W-1:0]  out_pc;

    modport master (
        output redirect,
        output redirect_pc,
        output mem_rdata,
        output out_ready,
        input  mem_raddr,
        input  out_valid,
        input  out_ins,
        input  out_pc
    );

    modport slave (
        input  redirect,
        input  redirect_pc,
        input  mem_rdata,
        input  out_ready,
        output mem_raddr,
        output out_valid,
        output out_ins,
        output out_pc
    );

endinterface

// File: rtl/fetch_byte_buf.sv
// Byte FIFO of BUF_BYTES entries, head at index 0.
// Pops two bytes, then appends one or two bytes at the tail.
module fetch_byte_buf
    import fetch_align_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              pop,
    input  push_t             push,
    output logic [CNT_W-1:0]  count,
    output logic [WORD_W-1:0] head
);

    logic [7:0]       byte_q [BUF_BYTES];
    logic [7:0]       byte_d [BUF_BYTES];
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        base = cnt_after(count, pop);
        byte_d = byte_q;
        if (pop) begin
            byte_d[0] = byte_q[2];
            byte_d[1] = byte_q[3];
        end
        count_d = base;
        if (push.valid) begin
            if (push.hi_only) begin
                count_d = base + CNT_W'(1);
            end else begin
                count_d = base + CNT_W'(2);
            end
            for (int i = 0; i < BUF_BYTES; i++) begin
                if (push.hi_only) begin
                    if (CNT_W'(i) == base)
                        byte_d[i] = push.word[15:8];
                end else begin
                    if (CNT_W'(i) == base)
                        byte_d[i] = push.word[7:0];
                    if (CNT_W'(i) == base + CNT_W'(1))
                        byte_d[i] = push.word[15:8];
                end
            end
        end
        if (clr)
            count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < BUF_BYTES; i++)
                byte_q[i] <= '0;
        end else begin
            count  <= count_d;
            byte_q <= byte_d;
        end
    end

    assign head = {byte_q[1], byte_q[0]};

endmodule

// File: rtl/fetch_align.sv
// Turns a word-organised fetch stream into byte-aligned 16-bit
// instructions; handles odd redirect targets and address wrap.
module fetch_align
    import fetch_align_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_align_if.slave bus
);

    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   rest;
    logic [CNT_W:0]     need;
    logic [WORD_W-1:0]  head;
    logic [WADDR_W-1:0] fetch_addr;
    logic [WORD_W-1:0]  pc;
    logic               in_flight;
    logic               skip;
    logic               valid;
    logic               xfer;
    logic               issue;
    push_t              push;

    always_comb begin
        valid = (count >= CNT_W'(2)) && !bus.redirect;
        xfer  = valid && bus.out_ready;
        rest  = cnt_after(count, xfer);
        // occupancy once the returning word and a new read both land
        need  = {1'b0, rest} + {2'b0, in_flight, 1'b0} + 4'd2;
        issue = bus.redirect || (need <= 4'(BUF_BYTES));
        push.valid   = in_flight && !bus.redirect;
        push.hi_only = skip;
        push.word    = bus.mem_rdata;
    end

    fetch_byte_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.redirect),
        .pop   (xfer),
        .push  (push),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight  <= 1'b0;
            skip       <= 1'b0;
            fetch_addr <= '0;
            pc         <= '0;
        end else begin
            in_flight <= issue;
            if (bus.redirect) begin
                fetch_addr <= bus.redirect_pc[15:1] + 1'b1;
                pc         <= bus.redirect_pc;
                skip       <= bus.redirect_pc[0];
            end else begin
                if (issue)
                    fetch_addr <= fetch_addr + 1'b1;
                if (xfer)
                    pc <= pc + 16'd2;
                if (in_flight)
                    skip <= 1'b0;
            end
        end
    end

    assign bus.mem_raddr = bus.redirect ? bus.redirect_pc[15:1]
                                        : fetch_addr;
    assign bus.out_valid = valid;
    assign bus.out_ins   = head;
    assign bus.out_pc    = pc;

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: directed phases push expected
// {pc, ins} pairs; a negedge monitor pops and compares on transfer.
module tb_fetch_align;
    import fetch_align_pkg::*;

    logic clk;
    logic rst;
    fetch_align_if bus ();

    fetch_align dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [32768];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    int n_chk;
    int n_pass;
    int n_xfer;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk)
        bus.mem_rdata <= mem[bus.mem_raddr];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL xfer_extra: got pc=%h ins=%h required none",
                         bus.out_pc, bus.out_ins);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("xfer", {bus.out_pc, bus.out_ins}, mon_exp);
            end
            n_xfer++;
        end
    end

    task automatic lat_check(input string name,
                             input int exp_lat,
                             input int exp_raddr);
        int lat;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0)
                chk({name, "_raddr"}, 32'(bus.mem_raddr), exp_raddr);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
            bus.redirect = 1'b0;
        end
        chk({name, "_lat"}, lat, exp_lat);
    endtask

    task automatic wait_xfers(input string name,
                              input int target,
                              output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (n_xfer < target && cyc < 50);
        chk({name, "_count"}, n_xfer, target);
    endtask

    task automatic go_redirect(input logic [15:0] pc);
        @(posedge clk);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int base;
        n_chk = 0;
        n_pass = 0;
        n_xfer = 0;
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        mem[0] = 16'h1111; mem[1] = 16'h2222;
        mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[4] = 16'h5555; mem[5] = 16'h6666;
        mem[6] = 16'h7777; mem[7] = 16'h8888;
        mem[8] = 16'h9999; mem[9] = 16'hAAAA;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ins", 32'(bus.out_ins), 0);
        chk("rst_pc", 32'(bus.out_pc), 0);

        // reset release, streaming at one per cycle
        exp_q.push_back({16'h0000, 16'h1111});
        exp_q.push_back({16'h0002, 16'h2222});
        exp_q.push_back({16'h0004, 16'h3333});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat_check("A", 2, 0);
        wait_xfers("A", 3, cyc);
        chk("A_cycles", cyc, 3);
        #1;
        bus.out_ready = 1'b0;

        // stall with a full buffer
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_count", 32'(dut.count), 4);
            chk("stall_ins", 32'(bus.out_ins), 32'h4444);
            chk("stall_raddr", 32'(bus.mem_raddr), 5);
        end
        exp_q.push_back({16'h0006, 16'h4444});
        exp_q.push_back({16'h0008, 16'h5555});
        exp_q.push_back({16'h000A, 16'h6666});
        exp_q.push_back({16'h000C, 16'h7777});
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_xfers("B", 7, cyc);

        // redirect while an instruction is presented and a word returns
        exp_q.push_back({16'h0010, 16'h9999});
        exp_q.push_back({16'h0012, 16'hAAAA});
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0010;
        lat_check("D", 2, 8);
        wait_xfers("D", 9, cyc);
        #1;
        bus.out_ready = 1'b0;

        // odd redirect target
        mem[2] = 16'hAB12; mem[3] = 16'hCD34; mem[4] = 16'h5E6F;
        repeat (3) @(posedge clk);
        exp_q.push_back({16'h0005, 16'h34AB});
        exp_q.push_back({16'h0007, 16'h6FCD});
        base = n_xfer;
        go_redirect(16'h0005);
        bus.out_ready = 1'b1;
        lat_check("C", 3, 2);
        wait_xfers("C", base + 2, cyc);
        #1;
        bus.out_ready = 1'b0;

        // address wrap on an odd pc
        mem[32767] = 16'h00EE; mem[0] = 16'h0077; mem[1] = 16'h1357;
        repeat (3) @(posedge clk);
        exp_q.push_back({16'hFFFF, 16'h7700});
        exp_q.push_back({16'h0001, 16'h5700});
        base = n_xfer;
        go_redirect(16'hFFFF);
        bus.out_ready = 1'b1;
        lat_check("E", 3, 32'h7FFF);
        wait_xfers("E", base + 2, cyc);
        #1;
        bus.out_ready = 1'b0;

        // reset mid-stream with 3 bytes held
        repeat (3) @(posedge clk);
        go_redirect(16'h0003);
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("F_pre_count", 32'(dut.count), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back({16'h0000, 16'h0077});
        exp_q.push_back({16'h0002, 16'h1357});
        base = n_xfer;
        bus.out_ready = 1'b1;
        lat_check("F", 2, 0);
        wait_xfers("F", base + 2, cyc);
        #1;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
